wait_state_ctrl: RTL and testbench

- Parametrised successor to the chipset READY logic: a bus-cycle wait-state generator with a programmable address-region table.
- Every CPU or DMA bus cycle gets a per-region fixed wait count, then is stretched by a synchronised io_channel_ready.
- A watchdog ends cycles stuck on a not-ready device.
- Sits between the bus arbiter command strobes and the CPU READY input; the region table is driven by configuration registers outside this block.

---
 rtl/wait_state_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_wait_state_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_ctrl.sv
// Bus-cycle wait-state generator: per-region fixed wait count, then stretched by a
// synchronised device ready, with a watchdog that forces completion of stuck cycles.
module wait_state_ctrl #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_WIDTH  = 20,
  parameter int WS_WIDTH    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic                              io_read_n,
  input  logic                              io_write_n,
  input  logic                              memory_read_n,
  input  logic                              memory_write_n,
  input  logic                              address_enable_n,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_base,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_mask,
  input  logic [NUM_REGIONS-1:0]            region_is_io,
  input  logic [NUM_REGIONS*WS_WIDTH-1:0]   region_wait,
  input  logic [WS_WIDTH-1:0]               default_wait,
  input  logic                              io_channel_ready,
  output logic                              processor_ready,
  output logic                              cycle_active,
  output logic [NUM_REGIONS-1:0]            region_hit,
  output logic                              timeout_pulse
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_EXTEND = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [WS_WIDTH-1:0] CNT_ONE   = WS_WIDTH'(1);
  localparam logic [15:0]         TIMEOUT_C = 16'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rdy_s;
  logic                   cmd_s;
  logic                   is_io_s;
  logic [NUM_REGIONS-1:0] match_hit_s;
  logic                   match_found_s;
  logic [WS_WIDTH-1:0]    match_wait_s;
  logic [NUM_REGIONS-1:0] sel_hit_s;
  logic [WS_WIDTH-1:0]    sel_wait_s;
  logic [15:0]            tcnt_inc_s;

  logic [1:0]             state_q, state_d;
  logic [WS_WIDTH-1:0]    cnt_q, cnt_d;
  logic [15:0]            tcnt_q, tcnt_d;
  logic [NUM_REGIONS-1:0] hit_q, hit_d;
  logic                   timeout_q, timeout_d;
  logic                   ready_q, ready_d;
  logic                   active_q, active_d;

  assign rdy_s      = sync_q[SYNC_STAGES-1];
  assign cmd_s      = ~(io_read_n & io_write_n & memory_read_n & memory_write_n);
  assign is_io_s    = ~io_read_n | ~io_write_n;
  assign tcnt_inc_s = tcnt_q + 16'd1;

  // Synchroniser resets high so a reset never looks like a not-ready device.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_channel_ready};
    end
  end

  // Region table lookup, lowest index wins; DMA cycles bypass the table.
  always_comb begin
    match_hit_s   = '0;
    match_found_s = 1'b0;
    match_wait_s  = default_wait;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!match_found_s &&
          ((address & region_mask[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
           (region_base[i*ADDR_WIDTH +: ADDR_WIDTH] & region_mask[i*ADDR_WIDTH +: ADDR_WIDTH])) &&
          (region_is_io[i] == is_io_s)) begin
        match_found_s  = 1'b1;
        match_hit_s[i] = 1'b1;
        match_wait_s   = region_wait[i*WS_WIDTH +: WS_WIDTH];
      end else begin
        match_found_s = match_found_s;
      end
    end
    if (address_enable_n) begin
      sel_hit_s  = '0;
      sel_wait_s = default_wait;
    end else begin
      sel_hit_s  = match_hit_s;
      sel_wait_s = match_wait_s;
    end
  end

  // Cycle sequencing: fixed wait, ready extension with watchdog, hold until strobes release.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    hit_d     = hit_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_s) begin
          hit_d  = sel_hit_s;
          tcnt_d = 16'd0;
          if (sel_wait_s == '0) begin
            cnt_d   = '0;
            state_d = rdy_s ? ST_DONE : ST_EXTEND;
          end else begin
            cnt_d   = sel_wait_s;
            state_d = ST_WAIT;
          end
        end else begin
          hit_d = '0;
        end
      end
      ST_WAIT: begin
        if (!cmd_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tcnt_d  = 16'd0;
          hit_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          cnt_d   = '0;
          tcnt_d  = 16'd0;
          state_d = rdy_s ? ST_DONE : ST_EXTEND;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_EXTEND: begin
        if (!cmd_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tcnt_d  = 16'd0;
          hit_d   = '0;
        end else if (rdy_s) begin
          state_d = ST_DONE;
          tcnt_d  = 16'd0;
        end else if (tcnt_inc_s == TIMEOUT_C) begin
          state_d   = ST_DONE;
          tcnt_d    = 16'd0;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_inc_s;
        end
      end
      ST_DONE: begin
        if (!cmd_s) begin
          state_d = ST_IDLE;
          hit_d   = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tcnt_d  = 16'd0;
        hit_d   = '0;
      end
    endcase
    ready_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);
    active_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tcnt_q    <= 16'd0;
      hit_q     <= '0;
      timeout_q <= 1'b0;
      ready_q   <= 1'b1;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      hit_q     <= hit_d;
      timeout_q <= timeout_d;
      ready_q   <= ready_d;
      active_q  <= active_d;
    end
  end

  assign processor_ready = ready_q;
  assign cycle_active    = active_q;
  assign region_hit      = hit_q;
  assign timeout_pulse   = timeout_q;

endmodule

// File: tb/tb_wait_state_ctrl.sv
// Self-checking bench for wait_state_ctrl: directed scenarios plus randomized bus
// cycles, all compared every clock against a cycle-level behavioural model.
module tb_wait_state_ctrl;

  localparam int NR = 4;
  localparam int AW = 20;
  localparam int WS = 4;
  localparam int SS = 2;
  localparam int TO = 15;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n;
  logic [AW-1:0]     address;
  logic              io_read_n, io_write_n, memory_read_n, memory_write_n;
  logic              address_enable_n;
  logic [NR*AW-1:0]  region_base, region_mask;
  logic [NR-1:0]     region_is_io;
  logic [NR*WS-1:0]  region_wait;
  logic [WS-1:0]     default_wait;
  logic              io_channel_ready;
  logic              processor_ready, cycle_active, timeout_pulse;
  logic [NR-1:0]     region_hit;

  wait_state_ctrl #(
    .NUM_REGIONS(NR), .ADDR_WIDTH(AW), .WS_WIDTH(WS), .SYNC_STAGES(SS), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address),
    .io_read_n(io_read_n), .io_write_n(io_write_n),
    .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .address_enable_n(address_enable_n),
    .region_base(region_base), .region_mask(region_mask),
    .region_is_io(region_is_io), .region_wait(region_wait),
    .default_wait(default_wait), .io_channel_ready(io_channel_ready),
    .processor_ready(processor_ready), .cycle_active(cycle_active),
    .region_hit(region_hit), .timeout_pulse(timeout_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int low_cnt  = 0;
  int pulse_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a bus cycle is "busy" from its start until strobes release;
  // it finishes after its wait count, then when the synchronised ready is seen or
  // after TO clocks of extension.
  bit          m_busy, m_fin, m_to;
  int          m_wl, m_ext;
  bit [NR-1:0] m_hit;
  bit          m_hist [SS];

  task automatic model_reset();
    m_busy = 1'b0; m_fin = 1'b0; m_to = 1'b0; m_wl = 0; m_ext = 0; m_hit = '0;
    for (int i = 0; i < SS; i++) m_hist[i] = 1'b1;
  endtask

  task automatic model_step();
    bit cmd, io, rdy;
    int w;
    bit [NR-1:0] h;
    logic [AW-1:0] msk;
    cmd = !(io_read_n && io_write_n && memory_read_n && memory_write_n);
    io  = !io_read_n || !io_write_n;
    rdy = m_hist[SS-1];
    for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = io_channel_ready;
    m_to = 1'b0;
    if (!m_busy) begin
      if (cmd) begin
        h = '0;
        w = int'(default_wait);
        if (!address_enable_n) begin
          for (int i = 0; i < NR; i++) begin
            msk = region_mask[i*AW +: AW];
            if (h == '0 && (address & msk) == (region_base[i*AW +: AW] & msk) &&
                region_is_io[i] == io) begin
              h = NR'(1) << i;
              w = int'(region_wait[i*WS +: WS]);
            end
          end
        end
        m_busy = 1'b1; m_hit = h; m_ext = 0; m_wl = w;
        m_fin = (w == 0) && rdy;
      end
    end else if (!cmd) begin
      m_busy = 1'b0; m_fin = 1'b0; m_hit = '0; m_wl = 0; m_ext = 0;
    end else if (m_fin) begin
      m_fin = 1'b1;
    end else if (m_wl > 0) begin
      m_wl--;
      if (m_wl == 0 && rdy) m_fin = 1'b1;
    end else if (rdy) begin
      m_fin = 1'b1;
    end else begin
      m_ext++;
      if (m_ext == TO) begin
        m_fin = 1'b1;
        m_to  = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    chk("ready",   32'(processor_ready), 32'(!m_busy || m_fin));
    chk("active",  32'(cycle_active),    32'(m_busy));
    chk("hit",     32'(region_hit),      32'(m_hit));
    chk("timeout", 32'(timeout_pulse),   32'(m_to));
    if (!processor_ready) low_cnt++;
    if (timeout_pulse) pulse_cnt++;
  endtask

  task automatic set_strobes(input logic [3:0] s);
    {io_read_n, io_write_n, memory_read_n, memory_write_n} = s;
  endtask

  task automatic set_region(input int i, input logic [AW-1:0] b, input logic [AW-1:0] m,
                            input logic io, input logic [WS-1:0] w);
    region_base[i*AW +: AW] = b;
    region_mask[i*AW +: AW] = m;
    region_is_io[i]         = io;
    region_wait[i*WS +: WS] = w;
  endtask

  task automatic clear_regions();
    for (int i = 0; i < NR; i++) set_region(i, 20'hFFFFF, 20'hFFFFF, 1'b1, 4'd0);
  endtask

  int k;
  int len;
  int r;
  logic [AW-1:0] mk;

  initial begin
    reset_n = 1'b0;
    address = '0;
    set_strobes(4'b1111);
    address_enable_n = 1'b0;
    clear_regions();
    default_wait = 4'd0;
    io_channel_ready = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("rst_ready",  32'(processor_ready), 32'd1);
    chk("rst_active", 32'(cycle_active),    32'd0);
    chk("rst_hit",    32'(region_hit),      32'd0);
    chk("rst_to",     32'(timeout_pulse),   32'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    // I/O region 1 with 3 waits, device ready.
    set_region(1, 20'h003F8, 20'hFFFF8, 1'b1, 4'd3);
    address = 20'h003FA;
    set_strobes(4'b0111);
    low_cnt = 0;
    repeat (8) tick();
    chk("io_low_clocks", 32'(low_cnt), 32'd3);
    chk("io_hit", 32'(region_hit), 32'b0010);
    chk("io_hold_ready", 32'(processor_ready), 32'd1);
    set_strobes(4'b1111);
    repeat (2) tick();

    // Memory miss, no waits, device late.
    clear_regions();
    io_channel_ready = 1'b0;
    repeat (3) tick();
    address = 20'hB8000;
    set_strobes(4'b1101);
    low_cnt = 0;
    repeat (11) tick();
    chk("mem_ext_low", 32'(low_cnt), 32'd11);
    chk("mem_hit", 32'(region_hit), 32'd0);
    io_channel_ready = 1'b1;
    k = 0;
    while (!processor_ready && k < 10) begin
      tick();
      k++;
    end
    chk("ready_rise_latency", 32'(k), 32'(SS + 1));
    set_strobes(4'b1111);
    repeat (2) tick();

    // Overlapping regions 0 and 2; then the same access as DMA.
    set_region(0, 20'h12000, 20'hFF000, 1'b0, 4'd5);
    set_region(2, 20'h12340, 20'hFFFF0, 1'b0, 4'd1);
    address = 20'h12345;
    set_strobes(4'b1110);
    low_cnt = 0;
    repeat (10) tick();
    chk("overlap_low", 32'(low_cnt), 32'd5);
    chk("overlap_hit", 32'(region_hit), 32'b0001);
    set_strobes(4'b1111);
    repeat (2) tick();
    address_enable_n = 1'b1;
    default_wait = 4'd2;
    set_strobes(4'b1110);
    low_cnt = 0;
    repeat (6) tick();
    chk("dma_low", 32'(low_cnt), 32'd2);
    chk("dma_hit", 32'(region_hit), 32'd0);
    set_strobes(4'b1111);
    address_enable_n = 1'b0;
    default_wait = 4'd0;
    repeat (2) tick();

    // Watchdog.
    clear_regions();
    io_channel_ready = 1'b0;
    repeat (3) tick();
    address = 20'h00100;
    set_strobes(4'b1101);
    low_cnt = 0;
    pulse_cnt = 0;
    repeat (20) tick();
    chk("wd_low", 32'(low_cnt), 32'(TO));
    chk("wd_pulses", 32'(pulse_cnt), 32'd1);
    chk("wd_ready", 32'(processor_ready), 32'd1);
    set_strobes(4'b1111);
    io_channel_ready = 1'b1;
    repeat (3) tick();

    // Abort two clocks into a 6-wait cycle, then restart after one idle clock.
    set_region(3, 20'h40000, 20'hF0000, 1'b0, 4'd6);
    address = 20'h40010;
    set_strobes(4'b1101);
    pulse_cnt = 0;
    repeat (2) tick();
    set_strobes(4'b1111);
    tick();
    chk("abort_ready", 32'(processor_ready), 32'd1);
    chk("abort_active", 32'(cycle_active), 32'd0);
    set_strobes(4'b1101);
    low_cnt = 0;
    repeat (10) tick();
    chk("restart_low", 32'(low_cnt), 32'd6);
    chk("abort_pulses", 32'(pulse_cnt), 32'd0);
    set_strobes(4'b1111);
    repeat (2) tick();

    // Asynchronous reset in the middle of an extension.
    io_channel_ready = 1'b0;
    address = 20'h00200;
    repeat (3) tick();
    set_strobes(4'b0111);
    repeat (5) tick();
    chk("pre_rst_ready", 32'(processor_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ready",  32'(processor_ready), 32'd1);
    chk("async_rst_active", 32'(cycle_active),    32'd0);
    chk("async_rst_hit",    32'(region_hit),      32'd0);
    model_reset();
    set_strobes(4'b1111);
    io_channel_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) tick();

    // Randomized bus cycles with a random region table that shifts under the bus.
    for (int i = 0; i < NR; i++) begin
      mk = AW'(20'hFFFFF << $urandom_range(0, 12));
      set_region(i, AW'($urandom), mk, 1'($urandom_range(0, 1)), WS'($urandom_range(0, 4)));
    end
    default_wait = WS'($urandom_range(0, 3));
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 1) == 0)
        address = region_base[r*AW +: AW] + AW'($urandom_range(0, 15));
      else
        address = AW'($urandom);
      case ($urandom_range(0, 3))
        0: set_strobes(4'b0111);
        1: set_strobes(4'b1011);
        2: set_strobes(4'b1101);
        default: set_strobes(4'b1110);
      endcase
      address_enable_n = ($urandom_range(0, 4) == 0);
      len = $urandom_range(1, 25);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) io_channel_ready = ~io_channel_ready;
        if ($urandom_range(0, 7) == 0)
          region_wait[r*WS +: WS] = WS'($urandom_range(0, 4));
        if ($urandom_range(0, 9) == 0) address = AW'($urandom);
        tick();
      end
      if ($urandom_range(0, 5) != 0) begin
        set_strobes(4'b1111);
        len = $urandom_range(1, 3);
        for (int c = 0; c < len; c++) begin
          if ($urandom_range(0, 3) == 0) io_channel_ready = ~io_channel_ready;
          tick();
        end
      end
      if ($urandom_range(0, 9) == 0) default_wait = WS'($urandom_range(0, 3));
    end
    set_strobes(4'b1111);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
